// File: rtl/spi_scheduler.sv
// spi_scheduler
//   Shares one SPI engine between a display writer (8/9-bit words) and an ADC
//   reader (16-bit results). Round-robin arbitration, chip-select setup/gap
//   timing, completion detection from the engine's done, and a done-timeout.
//
//   Handshake: wr_req / rd_req are levels held by the requester until the
//   matching one-cycle wr_ack / rd_ack. Requests are only sampled in IDLE.
//   A request still high after its ack competes again once GAP has elapsed.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   wr_req, wr_nine     write request, 9-bit select
//   wr_word[8:0]        write word (latched at grant)
//   wr_ack              one-cycle write-finished pulse
//   rd_req              read request
//   rd_ack, rd_data     one-cycle read-finished pulse, last captured result
//   err                 one-cycle pulse alongside the ack of a timed-out transfer
//   busy                high in every state except IDLE
//   spi_load, spi_mode  engine load, engine mode (0 8-bit, 1 9-bit, 2 read, 3 parked)
//   spi_word_8/9        latched write word for the engine
//   spi_done, spi_fifo  engine done, engine read shift register
//   cs_lcd_n, cs_adc_n  active-low chip selects
//   dbg_state           current FSM state, for observation only
module spi_scheduler #(
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic        wr_nine,
  input  logic [8:0]  wr_word,
  output logic        wr_ack,
  input  logic        rd_req,
  output logic        rd_ack,
  output logic [15:0] rd_data,
  output logic        err,
  output logic        busy,
  output logic        spi_load,
  output logic [1:0]  spi_mode,
  output logic [7:0]  spi_word_8,
  output logic [8:0]  spi_word_9,
  input  logic        spi_done,
  input  logic [15:0] spi_fifo,
  output logic        cs_lcd_n,
  output logic        cs_adc_n,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_XFER   = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  localparam logic [1:0] MODE_W8   = 2'd0;
  localparam logic [1:0] MODE_W9   = 2'd1;
  localparam logic [1:0] MODE_RD   = 2'd2;
  localparam logic [1:0] MODE_PARK = 2'd3;

  // Counter reload values: a state with reload N-1 lasts N cycles, leaving
  // on the edge where the counter reads zero.
  localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
  localparam logic [7:0] GAP_LD   = 8'(CS_GAP - 1);
  localparam logic [7:0] XFER_LD  = 8'(TIMEOUT - 1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic       grant_rd;
  logic       last_rd;   // 1: the most recent grant went to the reader
  logic       pick_rd;

  // On a tie the side that did not win last time gets the grant.
  assign pick_rd   = rd_req && (!wr_req || !last_rd);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      grant_rd   <= 1'b0;
      last_rd    <= 1'b1;
      wr_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      rd_data    <= 16'd0;
      spi_load   <= 1'b0;
      spi_mode   <= MODE_PARK;
      spi_word_8 <= 8'd0;
      spi_word_9 <= 9'd0;
      cs_lcd_n   <= 1'b1;
      cs_adc_n   <= 1'b1;
    end else begin
      wr_ack <= 1'b0;
      rd_ack <= 1'b0;
      err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_req || rd_req) begin
            grant_rd <= pick_rd;
            last_rd  <= pick_rd;
            busy     <= 1'b1;
            cnt      <= SETUP_LD;
            state    <= S_SETUP;
            if (pick_rd) begin
              spi_mode <= MODE_RD;
              cs_adc_n <= 1'b0;
            end else begin
              spi_mode   <= wr_nine ? MODE_W9 : MODE_W8;
              spi_word_8 <= wr_word[7:0];
              spi_word_9 <= wr_word;
              cs_lcd_n   <= 1'b0;
            end
          end
        end
        S_SETUP: begin
          if (cnt == 8'd0) begin
            spi_load <= 1'b1;
            cnt      <= XFER_LD;
            state    <= S_XFER;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_XFER: begin
          // On the first XFER cycle the counter still holds its reload value
          // and the engine has not left its start state, so done is ignored.
          if (cnt != XFER_LD && spi_done) begin
            spi_load <= 1'b0;
            wr_ack   <= !grant_rd;
            rd_ack   <= grant_rd;
            if (grant_rd) rd_data <= spi_fifo;
            cnt      <= 8'd0;
            state    <= S_FINISH;
          end else if (cnt == 8'd0) begin
            // Timed out: finish with err, leave rd_data alone.
            spi_load <= 1'b0;
            wr_ack   <= !grant_rd;
            rd_ack   <= grant_rd;
            err      <= 1'b1;
            state    <= S_FINISH;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_FINISH: begin
          cs_lcd_n <= 1'b1;
          cs_adc_n <= 1'b1;
          spi_mode <= MODE_PARK;
          cnt      <= GAP_LD;
          state    <= S_GAP;
        end
        S_GAP: begin
          if (cnt == 8'd0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          spi_load <= 1'b0;
          spi_mode <= MODE_PARK;
          cs_lcd_n <= 1'b1;
          cs_adc_n <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_scheduler.sv
module tb_spi_scheduler;

  localparam int CS_SETUP = 2;
  localparam int CS_GAP   = 4;
  localparam int TIMEOUT  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0;
  logic        wr_nine = 1'b0;
  logic [8:0]  wr_word = 9'd0;
  logic        wr_ack;
  logic        rd_req = 1'b0;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic        err;
  logic        busy;
  logic        spi_load;
  logic [1:0]  spi_mode;
  logic [7:0]  spi_word_8;
  logic [8:0]  spi_word_9;
  logic        spi_done = 1'b0;
  logic [15:0] spi_fifo;
  logic        cs_lcd_n;
  logic        cs_adc_n;
  logic [2:0]  dbg_state;

  spi_scheduler #(.CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_nine(wr_nine), .wr_word(wr_word), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
    .err(err), .busy(busy),
    .spi_load(spi_load), .spi_mode(spi_mode),
    .spi_word_8(spi_word_8), .spi_word_9(spi_word_9),
    .spi_done(spi_done), .spi_fifo(spi_fifo),
    .cs_lcd_n(cs_lcd_n), .cs_adc_n(cs_adc_n),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- engine model ----------------
  // Raises done once load has been high for the word length of the mode.
  logic        engine_dead = 1'b0;
  logic [15:0] rd_pattern  = 16'd0;
  logic [4:0]  ecnt = 5'd0;
  assign spi_fifo = rd_pattern;

  function automatic int bits_for(input logic [1:0] m);
    case (m)
      2'd0:    return 8;
      2'd1:    return 9;
      default: return 16;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!spi_load) begin
      ecnt     <= 5'd0;
      spi_done <= 1'b0;
    end else if (!engine_dead) begin
      ecnt <= ecnt + 5'd1;
      if (int'(ecnt) + 1 >= bits_for(spi_mode)) spi_done <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        rd;
    logic        er;
    logic [1:0]  mode;
    logic [8:0]  word;
    logic [15:0] data;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void push_wr(input logic [8:0] w, input logic nine);
    exp_t e;
    e.rd = 1'b0; e.er = 1'b0; e.mode = nine ? 2'd1 : 2'd0; e.word = w; e.data = 16'd0;
    exp_q.push_back(e);
  endfunction

  function automatic void push_rd(input logic er, input logic [15:0] d);
    exp_t e;
    e.rd = 1'b1; e.er = er; e.mode = 2'd2; e.word = 9'd0; e.data = d;
    exp_q.push_back(e);
  endfunction

  // ---------------- monitor ----------------
  int         setup_cnt = 0;
  int         load_cycles = 0;
  int         gap_cnt = 0;
  logic       seen_load = 1'b0;
  logic [1:0] cap_mode = 2'd3;
  logic [7:0] cap_w8 = 8'd0;
  logic [8:0] cap_w9 = 9'd0;

  always @(negedge clk) begin
    if (!rst) begin
      if (cs_lcd_n && cs_adc_n) begin
        setup_cnt   = 0;
        load_cycles = 0;
        seen_load   = 1'b0;
      end else if (spi_load) begin
        if (!seen_load) begin
          check("cs_setup_cycles", setup_cnt, CS_SETUP);
          seen_load = 1'b1;
          cap_mode  = spi_mode;
          cap_w8    = spi_word_8;
          cap_w9    = spi_word_9;
        end
        load_cycles++;
      end else if (!seen_load) begin
        setup_cnt++;
      end

      if (busy && cs_lcd_n && cs_adc_n && spi_mode == 2'd3 && !spi_load) begin
        gap_cnt++;
      end else if (!busy && gap_cnt != 0) begin
        check("cs_gap_cycles", gap_cnt, CS_GAP);
        gap_cnt = 0;
      end

      if (wr_ack || rd_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {wr_ack, rd_ack}, 2'b00);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ack_both", {31'd0, wr_ack & rd_ack}, 32'd0);
          check("ack_kind", {31'd0, rd_ack}, {31'd0, e.rd});
          check("err_flag", {31'd0, err}, {31'd0, e.er});
          check("mode_at_load", {30'd0, cap_mode}, {30'd0, e.mode});
          check("mode_in_finish", {30'd0, spi_mode}, {30'd0, e.mode});
          if (e.rd) check("rd_data", {16'd0, rd_data}, {16'd0, e.data});
          if (e.er) check("timeout_cycles", load_cycles, TIMEOUT);
          if (!e.rd && e.mode == 2'd0) check("word_8", {24'd0, cap_w8}, {24'd0, e.word[7:0]});
          if (!e.rd && e.mode == 2'd1) check("word_9", {23'd0, cap_w9}, {23'd0, e.word});
        end
      end else if (err) begin
        check("err_without_ack", {31'd0, err}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input int budget);
    int c;
    for (c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_write(input logic [8:0] w, input logic nine);
    logic got = 1'b0;
    logic scrambled = 1'b0;
    push_wr(w, nine);
    @(negedge clk);
    wr_word = w;
    wr_nine = nine;
    wr_req  = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      // Changing the inputs after the grant must not affect the transfer.
      if (!cs_lcd_n && !scrambled) begin
        wr_word   = ~w;
        wr_nine   = ~nine;
        scrambled = 1'b1;
      end
      if (wr_ack) begin
        got = 1'b1;
        break;
      end
    end
    wr_req = 1'b0;
    check("wr_ack_seen", {31'd0, got}, 32'd1);
    wait_idle(50);
  endtask

  task automatic do_read(input logic [15:0] pattern, input logic er, input logic [15:0] d);
    logic got = 1'b0;
    push_rd(er, d);
    @(negedge clk);
    rd_pattern = pattern;
    rd_req     = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (rd_ack) begin
        got = 1'b1;
        break;
      end
    end
    rd_req = 1'b0;
    check("rd_ack_seen", {31'd0, got}, 32'd1);
    wait_idle(50);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load"}, {31'd0, spi_load}, 32'd0);
    check({tag, "_mode"}, {30'd0, spi_mode}, 32'd3);
    check({tag, "_cs"}, {30'd0, cs_lcd_n, cs_adc_n}, 32'd3);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_acks"}, {29'd0, wr_ack, rd_ack, err}, 32'd0);
    check({tag, "_rd_data"}, {16'd0, rd_data}, 32'd0);
    check({tag, "_words"}, {15'd0, spi_word_9, spi_word_8}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int got;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2 rst = 1'b0;

    // Tie from reset: W first, then alternation W,R,W, then the held read.
    push_wr(9'h0A5, 1'b0);
    push_rd(1'b0, 16'h1234);
    push_wr(9'h0A5, 1'b0);
    push_rd(1'b0, 16'h1234);
    @(negedge clk);
    rd_pattern = 16'h1234;
    wr_word = 9'h0A5;
    wr_nine = 1'b0;
    wr_req = 1'b1;
    rd_req = 1'b1;
    got = 0;
    for (int c = 0; c < 600 && got < 4; c++) begin
      @(negedge clk);
      if (wr_ack || rd_ack) begin
        got++;
        if (got == 3) wr_req = 1'b0;
        if (got == 4) rd_req = 1'b0;
      end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    check("tie_ack_count", got, 4);
    wait_idle(50);

    // Plain transfers.
    do_write(9'h0A5, 1'b0);
    do_write(9'h1C3, 1'b1);
    do_read(16'h0ABC, 1'b0, 16'h0ABC);

    // Engine never finishes: timeout, err with ack, rd_data kept.
    engine_dead = 1'b1;
    do_read(16'h5555, 1'b1, 16'h0ABC);
    engine_dead = 1'b0;
    do_read(16'hBEEF, 1'b0, 16'hBEEF);

    // Reset in the middle of XFER: no ack, everything back to reset values.
    @(negedge clk);
    wr_word = 9'h03C;
    wr_nine = 1'b0;
    wr_req  = 1'b1;
    got = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (spi_load) begin
        got = 1;
        break;
      end
    end
    check("load_before_reset", got, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wr_req = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (30) @(negedge clk);
    check("no_ack_after_reset", exp_q.size(), 0);

    do_write(9'h15A, 1'b1);
    do_read(16'h8001, 1'b0, 16'h8001);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case something above never returns.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
